// File: rtl/qft3_measure_unit.sv
// Measurement back-end for the 3-qubit QFT core: snapshots eight complex amplitudes,
// scans |a|^2 one basis state per cycle, and reports argmax, total and a normalisation flag.
module qft3_measure_unit #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4,
  parameter int TOL    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*DATA_W-1:0]   amp_r,
  input  logic [8*DATA_W-1:0]   amp_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            out_index,
  output logic [2*DATA_W-1:0]   out_max,
  output logic [2*DATA_W+2:0]   out_sum,
  output logic                  norm_ok,
  input  logic [2:0]            rd_addr,
  output logic [2*DATA_W-1:0]   rd_prob,
  output logic [1:0]            dbg_state
);

  localparam int P_W = 2 * DATA_W;
  localparam int S_W = 2 * DATA_W + 3;
  localparam int D_W = 2 * DATA_W + 4;
  localparam logic signed [D_W-1:0] UNITY = D_W'(1) << (2 * FRAC_W);
  localparam logic signed [D_W-1:0] TOL_S = D_W'(TOL);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the producer holds data stable while valid && !ready.
  state_t                     state_q, state_d;
  logic [2:0]                 idx_q, idx_d;
  logic [P_W-1:0]             max_q, max_d;
  logic [2:0]                 max_idx_q, max_idx_d;
  logic [S_W-1:0]             sum_q, sum_d;
  logic signed [DATA_W-1:0]   snap_r_q [8];
  logic signed [DATA_W-1:0]   snap_r_d [8];
  logic signed [DATA_W-1:0]   snap_i_q [8];
  logic signed [DATA_W-1:0]   snap_i_d [8];
  logic [P_W-1:0]             prob_q [8];
  logic [P_W-1:0]             prob_d [8];
  logic                       out_valid_q, out_valid_d;
  logic [2:0]                 out_index_q, out_index_d;
  logic [P_W-1:0]             out_max_q, out_max_d;
  logic [S_W-1:0]             out_sum_q, out_sum_d;
  logic                       norm_ok_q, norm_ok_d;

  logic signed [DATA_W-1:0]   cur_r, cur_i;
  logic signed [P_W-1:0]      sq_r, sq_i;
  logic [P_W-1:0]             p;
  logic [S_W-1:0]             sum_next;
  logic [P_W-1:0]             max_next;
  logic [2:0]                 max_idx_next;
  logic signed [D_W-1:0]      diff, abs_diff;
  logic                       norm_next;

  // Full-precision squares; the sum of two squares always fits in P_W unsigned bits.
  always_comb begin
    cur_r        = snap_r_q[idx_q];
    cur_i        = snap_i_q[idx_q];
    sq_r         = cur_r * cur_r;
    sq_i         = cur_i * cur_i;
    p            = $unsigned(sq_r) + $unsigned(sq_i);
    sum_next     = sum_q + S_W'(p);
    max_next     = (p > max_q) ? p : max_q;
    max_idx_next = (p > max_q) ? idx_q : max_idx_q;
    diff         = $signed(D_W'(sum_next)) - UNITY;
    abs_diff     = (diff < 0) ? -diff : diff;
    norm_next    = (abs_diff <= TOL_S);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    max_d       = max_q;
    max_idx_d   = max_idx_q;
    sum_d       = sum_q;
    snap_r_d    = snap_r_q;
    snap_i_d    = snap_i_q;
    prob_d      = prob_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_max_d   = out_max_q;
    out_sum_d   = out_sum_q;
    norm_ok_d   = norm_ok_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < 8; k++) begin
            snap_r_d[k] = amp_r[k*DATA_W +: DATA_W];
            snap_i_d[k] = amp_i[k*DATA_W +: DATA_W];
          end
          idx_d     = 3'd0;
          max_d     = '0;
          max_idx_d = 3'd0;
          sum_d     = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        prob_d[idx_q] = p;
        sum_d         = sum_next;
        max_d         = max_next;
        max_idx_d     = max_idx_next;
        if (idx_q == 3'd7) begin
          out_max_d   = max_next;
          out_index_d = max_idx_next;
          out_sum_d   = sum_next;
          norm_ok_d   = norm_next;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      max_q       <= '0;
      max_idx_q   <= 3'd0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= 3'd0;
      out_max_q   <= '0;
      out_sum_q   <= '0;
      norm_ok_q   <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        snap_r_q[k] <= '0;
        snap_i_q[k] <= '0;
        prob_q[k]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      max_q       <= max_d;
      max_idx_q   <= max_idx_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_max_q   <= out_max_d;
      out_sum_q   <= out_sum_d;
      norm_ok_q   <= norm_ok_d;
      snap_r_q    <= snap_r_d;
      snap_i_q    <= snap_i_d;
      prob_q      <= prob_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_max   = out_max_q;
  assign out_sum   = out_sum_q;
  assign norm_ok   = norm_ok_q;
  assign rd_prob   = prob_q[rd_addr];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_qft3_measure_unit.sv
// Directed bench for qft3_measure_unit: hand-computed probabilities, argmax, sum and norm flag
// across basis, uniform, mixed-sign, back-pressure, mid-scan reset and extreme-value vectors.
module tb_qft3_measure_unit;

  localparam int DW = 8;
  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + 3;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [8*DW-1:0] amp_r;
  logic [8*DW-1:0] amp_i;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_index;
  logic [PW-1:0]   out_max;
  logic [SW-1:0]   out_sum;
  logic            norm_ok;
  logic [2:0]      rd_addr;
  logic [PW-1:0]   rd_prob;
  logic [1:0]      dbg_state;

  int n_vec;
  int n_miss;
  logic [PW-1:0] exp_q[$];

  qft3_measure_unit #(.DATA_W(DW), .FRAC_W(4), .TOL(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .amp_r(amp_r), .amp_i(amp_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_max(out_max), .out_sum(out_sum), .norm_ok(norm_ok),
    .rd_addr(rd_addr), .rd_prob(rd_prob), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic clear_amps();
    amp_r = '0;
    amp_i = '0;
  endtask

  task automatic set_amp(input int k, input int r, input int i);
    amp_r[k*DW +: DW] = DW'(r);
    amp_i[k*DW +: DW] = DW'(i);
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic check_results(input string tag, input int e_idx, input int e_max,
                               input int e_sum, input int e_norm);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_out_index"}, 32'(out_index), 32'(e_idx));
    check({tag, "_out_max"},   32'(out_max),   32'(e_max));
    check({tag, "_out_sum"},   32'(out_sum),   32'(e_sum));
    check({tag, "_norm_ok"},   32'(norm_ok),   32'(e_norm));
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      #1;
      check($sformatf("%s_rd_prob%0d", tag, k), 32'(rd_prob), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_released_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_released_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic load_basis();
    clear_amps();
    set_amp(0, 16, 0);
    for (int k = 0; k < 8; k++) exp_q.push_back((k == 0) ? PW'(256) : PW'(0));
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rd_addr   = 3'd0;
    clear_amps();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_max",   32'(out_max),   32'd0);
    check("rst_state",     32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // basis state
    load_basis();
    accept("basis");
    check("basis_scan_ready", 32'(in_ready), 32'd0);
    wait_result("basis", 8);
    check_results("basis", 0, 256, 256, 1);
    release_out("basis");

    // uniform superposition, ties keep index 0
    clear_amps();
    for (int k = 0; k < 8; k++) begin
      set_amp(k, 6, 0);
      exp_q.push_back(PW'(36));
    end
    accept("unif");
    wait_result("unif", 8);
    check_results("unif", 0, 36, 288, 1);
    release_out("unif");

    // mixed signs, max at last index
    clear_amps();
    set_amp(3, 11, 11);
    set_amp(5, -11, 11);
    set_amp(7, 0, -16);
    exp_q.push_back(PW'(0)); exp_q.push_back(PW'(0)); exp_q.push_back(PW'(0));
    exp_q.push_back(PW'(242)); exp_q.push_back(PW'(0)); exp_q.push_back(PW'(242));
    exp_q.push_back(PW'(0)); exp_q.push_back(PW'(256));
    accept("mixed");
    wait_result("mixed", 8);
    check_results("mixed", 7, 256, 740, 0);
    release_out("mixed");

    // back-pressure: uniform vector, then stray in_valid pulses carrying other data
    clear_amps();
    for (int k = 0; k < 8; k++) begin
      set_amp(k, 6, 0);
      exp_q.push_back(PW'(36));
    end
    accept("bp");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      clear_amps();
      set_amp(1, 16, 0);
      in_valid = 1'b1;
      check("bp_scan_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_result("bp", 5);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready),  32'd0);
      check("bp_hold_max",   32'(out_max),   32'd36);
      check("bp_hold_sum",   32'(out_sum),   32'd288);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check_results("bp", 0, 36, 288, 1);
    release_out("bp");
    load_basis();
    accept("bp_next");
    wait_result("bp_next", 8);
    check_results("bp_next", 0, 256, 256, 1);

    // reset mid-scan, with previous results still held
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    clear_amps();
    for (int k = 0; k < 8; k++) begin
      set_amp(k, 6, 0);
    end
    accept("rst_mid");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready",  32'(in_ready),  32'd1);
    check("rst_mid_out_index", 32'(out_index), 32'd0);
    check("rst_mid_out_max",   32'(out_max),   32'd0);
    check("rst_mid_out_sum",   32'(out_sum),   32'd0);
    check("rst_mid_norm_ok",   32'(norm_ok),   32'd0);
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      #1;
      check($sformatf("rst_mid_rd_prob%0d", k), 32'(rd_prob), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_basis();
    accept("after_rst");
    wait_result("after_rst", 8);
    check_results("after_rst", 0, 256, 256, 1);
    release_out("after_rst");

    // extreme negative amplitude
    clear_amps();
    set_amp(2, -128, -128);
    for (int k = 0; k < 8; k++) exp_q.push_back((k == 2) ? PW'(32768) : PW'(0));
    accept("extreme");
    wait_result("extreme", 8);
    check_results("extreme", 2, 32768, 32768, 0);
    release_out("extreme");

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
